// File: rtl/axi_burst_master_if.sv
// AXI4 bus bundle shared by axi_burst_master (master side) and a memory slave.
// Each of the five channels is carried in full: AW, W, B, AR, R.
interface axi_burst_master_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);

  // Write address channel
  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awlock;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;

  // Write data channel
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  // Write response channel
  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  // Read address channel
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;

  // Read data channel
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 master: one command becomes one INCR burst. Write beats
// are passed through from a valid/ready stream, read beats are passed out to one.
// Optional feature macro: AXI_BURST_MASTER_4K_CHECK_EN rejects commands whose burst
// would cross a 4 KB page (needs ADDR_WIDTH >= 12).
module axi_burst_master #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned ID_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  input  logic [DATA_WIDTH-1:0] s_wdata,
  input  logic [STRB_WIDTH-1:0] s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [DATA_WIDTH-1:0] m_rdata,
  output logic                  m_rlast,
  output logic                  m_rvalid,
  input  logic                  m_rready,
  output logic                  done_valid,
  output logic [1:0]            done_resp,
  output logic                  done_err,
  axi_burst_master_if.master    m_axi
);

  localparam int unsigned OffW = $clog2(STRB_WIDTH);
  localparam logic [2:0] AxSize = 3'(OffW);
  localparam logic [ADDR_WIDTH-1:0] AddrMask = {ADDR_WIDTH{1'b1}} << OffW;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StAw   = 3'd1;
  localparam logic [2:0] StW    = 3'd2;
  localparam logic [2:0] StB    = 3'd3;
  localparam logic [2:0] StAr   = 3'd4;
  localparam logic [2:0] StR    = 3'd5;
  localparam logic [2:0] StDone = 3'd6;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [7:0]            beat_cnt_q, beat_cnt_d;
  logic [1:0]            resp_q, resp_d;
  logic                  err_q, err_d;

  logic [ADDR_WIDTH-1:0] addr_aligned;
  logic                  last_beat;
  logic                  run;
  logic                  crosses_4k;

  assign addr_aligned = cmd_addr & AddrMask;
  assign last_beat    = (beat_cnt_q == len_q);

  // State only clears at the next edge of a synchronous reset, so every handshake
  // output is also held low combinationally while rst_n is asserted.
  assign run = rst_n;

`ifdef AXI_BURST_MASTER_4K_CHECK_EN
  logic [31:0] span_end;
  assign span_end   = 32'(addr_aligned[11:0]) + (32'(cmd_len) + 32'd1) * STRB_WIDTH;
  assign crosses_4k = (span_end > 32'd4096);
`else
  assign crosses_4k = 1'b0;
`endif

  // Next-state logic: command latch, beat counting, response accumulation.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    id_d       = id_q;
    beat_cnt_d = beat_cnt_q;
    resp_d     = resp_q;
    err_d      = err_q;
    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          addr_d     = addr_aligned;
          len_d      = cmd_len;
          id_d       = cmd_id;
          beat_cnt_d = 8'd0;
          resp_d     = 2'b00;
          err_d      = 1'b0;
          state_d    = cmd_write ? StAw : StAr;
          if (crosses_4k) begin
            // Accepted but never issued: report SLVERR-style failure directly.
            resp_d  = 2'b10;
            err_d   = 1'b1;
            state_d = StDone;
          end
        end
      end
      StAw: begin
        if (m_axi.awready) state_d = StW;
      end
      StW: begin
        if (s_wvalid && m_axi.wready) begin
          if (last_beat) state_d = StB;
          else           beat_cnt_d = beat_cnt_q + 8'd1;
        end
      end
      StB: begin
        if (m_axi.bvalid) begin
          resp_d  = m_axi.bresp;
          state_d = StDone;
        end
      end
      StAr: begin
        if (m_axi.arready) state_d = StR;
      end
      StR: begin
        if (m_axi.rvalid && m_rready) begin
          if (m_axi.rresp > resp_q) resp_d = m_axi.rresp;
          if (m_axi.rlast != last_beat) err_d = 1'b1;
          // Our own beat count ends the burst even if the slave's rlast disagrees.
          if (last_beat) state_d = StDone;
          else           beat_cnt_d = beat_cnt_q + 8'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      len_q      <= '0;
      id_q       <= '0;
      beat_cnt_q <= '0;
      resp_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      id_q       <= id_d;
      beat_cnt_q <= beat_cnt_d;
      resp_q     <= resp_d;
      err_q      <= err_d;
    end
  end

  assign cmd_ready = run && (state_q == StIdle);

  // Address channels carry the latched command; attributes are fixed.
  assign m_axi.awid    = id_q;
  assign m_axi.awaddr  = addr_q;
  assign m_axi.awlen   = len_q;
  assign m_axi.awsize  = AxSize;
  assign m_axi.awburst = 2'b01;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awcache = 4'b0011;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = run && (state_q == StAw);

  assign m_axi.arid    = id_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arlen   = len_q;
  assign m_axi.arsize  = AxSize;
  assign m_axi.arburst = 2'b01;
  assign m_axi.arlock  = 1'b0;
  assign m_axi.arcache = 4'b0011;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = run && (state_q == StAr);

  // Write stream pass-through, only open in W.
  assign m_axi.wdata  = s_wdata;
  assign m_axi.wstrb  = s_wstrb;
  assign m_axi.wlast  = (state_q == StW) && last_beat;
  assign m_axi.wvalid = run && (state_q == StW) && s_wvalid;
  assign s_wready     = run && (state_q == StW) && m_axi.wready;

  assign m_axi.bready = run && (state_q == StB);

  // Read stream pass-through, only open in R.
  assign m_rdata      = m_axi.rdata;
  assign m_rlast      = m_axi.rlast;
  assign m_rvalid     = run && (state_q == StR) && m_axi.rvalid;
  assign m_axi.rready = run && (state_q == StR) && m_rready;

  assign done_valid = run && (state_q == StDone);
  assign done_resp  = done_valid ? resp_q : 2'b00;
  assign done_err   = done_valid && err_q;

  // Response IDs are deliberately ignored with a single burst in flight.
  logic unused_ids;
  assign unused_ids = ^{m_axi.bid, m_axi.rid};

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master with a behavioural AXI4 RAM slave.
// Honours AXI_BURST_MASTER_4K_CHECK_EN to pick the expected 4 KB behaviour.
module tb_axi_burst_master;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 16;
  localparam int unsigned IW = 8;
  localparam int unsigned SW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic [IW-1:0] cmd_id;
  logic [DW-1:0] s_wdata;
  logic [SW-1:0] s_wstrb;
  logic          s_wvalid, s_wready;
  logic [DW-1:0] m_rdata;
  logic          m_rlast, m_rvalid, m_rready;
  logic          done_valid;
  logic [1:0]    done_resp;
  logic          done_err;

  axi_burst_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) m_axi ();

  axi_burst_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .ID_WIDTH(IW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .cmd_id     (cmd_id),
    .s_wdata    (s_wdata),
    .s_wstrb    (s_wstrb),
    .s_wvalid   (s_wvalid),
    .s_wready   (s_wready),
    .m_rdata    (m_rdata),
    .m_rlast    (m_rlast),
    .m_rvalid   (m_rvalid),
    .m_rready   (m_rready),
    .done_valid (done_valid),
    .done_resp  (done_resp),
    .done_err   (done_err),
    .m_axi      (m_axi)
  );

  // ---------------- behavioural RAM slave ----------------
  logic [31:0] mem [0:16383];
  logic        aw_rdy, wr_act, b_vld, ar_rdy, rd_act;
  logic [13:0] wr_word, rd_word;
  logic [7:0]  rd_left;
  logic [IW-1:0] b_id, rd_id;
  int          rd_beat;
  int          aw_cnt, ar_cnt;
  logic [44:0] aw_seen, ar_seen;
  logic [1:0]  cfg_bresp;
  int          cfg_rlast_beat, cfg_slverr_beat;

  assign m_axi.awready = aw_rdy;
  assign m_axi.wready  = wr_act;
  assign m_axi.bvalid  = b_vld;
  assign m_axi.bresp   = cfg_bresp;
  assign m_axi.bid     = b_id;
  assign m_axi.arready = ar_rdy;
  assign m_axi.rvalid  = rd_act;
  assign m_axi.rdata   = mem[rd_word];
  assign m_axi.rresp   = (rd_beat == cfg_slverr_beat) ? 2'b10 : 2'b00;
  assign m_axi.rlast   = rd_act && ((rd_beat == cfg_rlast_beat) || (rd_left == 8'd0));
  assign m_axi.rid     = rd_id;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16384; i++) mem[i] <= 32'(i * 8);
      aw_rdy <= 1'b0; wr_act <= 1'b0; b_vld <= 1'b0;
      ar_rdy <= 1'b0; rd_act <= 1'b0;
      wr_word <= '0; rd_word <= '0; rd_left <= '0; rd_beat <= 0;
      b_id <= '0; rd_id <= '0;
    end else begin
      aw_rdy <= m_axi.awvalid && !aw_rdy && !wr_act && !b_vld;
      if (m_axi.awvalid && aw_rdy) begin
        wr_word <= m_axi.awaddr[15:2];
        wr_act  <= 1'b1;
        b_id    <= m_axi.awid;
        aw_cnt  <= aw_cnt + 1;
        aw_seen <= {m_axi.awid, m_axi.awaddr, m_axi.awlen, m_axi.awsize, m_axi.awburst,
                    m_axi.awlock, m_axi.awcache, m_axi.awprot};
      end
      if (m_axi.wvalid && wr_act) begin
        for (int b = 0; b < 4; b++)
          if (m_axi.wstrb[b]) mem[wr_word][b*8 +: 8] <= m_axi.wdata[b*8 +: 8];
        wr_word <= wr_word + 14'd1;
        if (m_axi.wlast) begin
          wr_act <= 1'b0;
          b_vld  <= 1'b1;
        end
      end
      if (b_vld && m_axi.bready) b_vld <= 1'b0;
      ar_rdy <= m_axi.arvalid && !ar_rdy && !rd_act;
      if (m_axi.arvalid && ar_rdy) begin
        rd_word <= m_axi.araddr[15:2];
        rd_left <= m_axi.arlen;
        rd_beat <= 0;
        rd_act  <= 1'b1;
        rd_id   <= m_axi.arid;
        ar_cnt  <= ar_cnt + 1;
        ar_seen <= {m_axi.arid, m_axi.araddr, m_axi.arlen, m_axi.arsize, m_axi.arburst,
                    m_axi.arlock, m_axi.arcache, m_axi.arprot};
      end
      if (rd_act && m_axi.rready) begin
        rd_word <= rd_word + 14'd1;
        rd_beat <= rd_beat + 1;
        if (rd_left == 8'd0) rd_act <= 1'b0;
        else                 rd_left <= rd_left - 8'd1;
      end
    end
  end

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  typedef struct {
    logic        write;
    logic [15:0] addr;
    logic [7:0]  len;
    logic [7:0]  id;
    logic [3:0]  strb;
    logic [31:0] dbase;
    logic        gap;
    int          rlast_beat;
    int          slverr_beat;
    logic [1:0]  bresp;
    logic [1:0]  exp_resp;
    logic        exp_err;
  } vec_t;

  function automatic vec_t mk(input logic w, input logic [15:0] a, input logic [7:0] l,
                              input logic [7:0] id, input logic [3:0] st,
                              input logic [31:0] db, input logic g, input int rb,
                              input int sb, input logic [1:0] br, input logic [1:0] er,
                              input logic ee);
    vec_t v;
    v.write = w; v.addr = a; v.len = l; v.id = id; v.strb = st; v.dbase = db; v.gap = g;
    v.rlast_beat = rb; v.slverr_beat = sb; v.bresp = br; v.exp_resp = er; v.exp_err = ee;
    return v;
  endfunction

  // Issue one command and follow it to completion, checking beats and the done pulse.
  task automatic run_cmd(input vec_t v);
    int          sent, got, budget, aw0, ar0, n_done, wait_cyc;
    logic        reject, exp_now, exp_next, done_seen, finished, exp_rlast;
    logic [13:0] w;
    logic [31:0] exp_d, orig;
    reject = 1'b0;
`ifdef AXI_BURST_MASTER_4K_CHECK_EN
    reject = ((32'(v.addr) & 32'hFFC) + (32'(v.len) + 32'd1) * 32'd4) > 32'd4096;
`endif
    cfg_bresp = v.bresp; cfg_rlast_beat = v.rlast_beat; cfg_slverr_beat = v.slverr_beat;
    aw0 = aw_cnt; ar0 = ar_cnt;
    wait_cyc = 0;
    @(negedge clk);
    while (!cmd_ready && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr; cmd_len = v.len; cmd_id = v.id;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    if (!reject) check("issue_latency", 64'(v.write ? m_axi.awvalid : m_axi.arvalid), 64'd1);
    sent = 0; got = 0; n_done = 0; exp_next = reject; done_seen = 1'b0; finished = 1'b0;
    budget = 30 + 3 * (int'(v.len) + 1);
    for (int cyc = 0; cyc < budget; cyc++) begin
      s_wvalid = v.write && (sent <= int'(v.len)) && !(v.gap && (cyc % 2 == 1));
      s_wdata  = v.dbase + 32'(sent);
      s_wstrb  = v.strb;
      m_rready = !v.write && !(v.gap && (cyc % 2 == 1));
      @(negedge clk);
      if (done_seen) begin
        check("ready_after_done", 64'(cmd_ready), 64'd1);
        check("done_once", 64'(done_valid), 64'd0);
        finished = 1'b1;
        break;
      end
      exp_now = exp_next;
      exp_next = 1'b0;
      if (exp_now || done_valid) begin
        check("done_timing", 64'(done_valid), 64'(exp_now));
        if (done_valid) begin
          n_done++;
          done_seen = 1'b1;
          check("done_resp", 64'(done_resp), 64'(v.exp_resp));
          check("done_err", 64'(done_err), 64'(v.exp_err));
        end
      end
      if (s_wvalid && s_wready) begin
        check("wlast", 64'(m_axi.wlast), 64'(sent == int'(v.len)));
        sent++;
      end
      if (m_rvalid && m_rready) begin
        exp_d = (32'(v.addr >> 2) + 32'(got)) * 32'd8;
        exp_rlast = (got == int'(v.len)) || (got == v.rlast_beat);
        check("rdata", 64'(m_rdata), 64'(exp_d));
        check("m_rlast", 64'(m_rlast), 64'(exp_rlast));
        got++;
        if (got == int'(v.len) + 1) exp_next = 1'b1;
      end
      if (m_axi.bvalid && m_axi.bready) exp_next = 1'b1;
      @(posedge clk);
      #1;
    end
    s_wvalid = 1'b0;
    m_rready = 1'b0;
    if (!finished) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: burst at 0x%0h got no done within %0d cycles", v.addr, budget);
    end
    check("done_count", 64'(n_done), 64'd1);
    if (v.write) begin
      check("aw_issued", 64'(aw_cnt - aw0), reject ? 64'd0 : 64'd1);
      if (!reject)
        check("aw_fields", 64'(aw_seen),
              64'({v.id, v.addr & 16'hFFFC, v.len, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000}));
      for (int k = 0; k <= int'(v.len); k++) begin
        w = 14'((32'(v.addr >> 2) + 32'(k)) & 32'h3FFF);
        orig = 32'(w) * 32'd8;
        exp_d = reject ? orig : merge(orig, v.dbase + 32'(k), v.strb);
        check("mem", 64'(mem[w]), 64'(exp_d));
      end
    end else begin
      check("ar_issued", 64'(ar_cnt - ar0), 64'd1);
      check("ar_fields", 64'(ar_seen),
            64'({v.id, v.addr & 16'hFFFC, v.len, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000}));
      check("beat_count", 64'(got), 64'(int'(v.len) + 1));
    end
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [9];
  logic [1:0] resp_4k;
  logic       err_4k;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

  initial begin
    int sent, spur;
    aw_cnt = 0; ar_cnt = 0; aw_seen = '0; ar_seen = '0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    cmd_id = '0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0; m_rready = 1'b0;
    cfg_bresp = 2'b00; cfg_rlast_beat = -1; cfg_slverr_beat = -1;

`ifdef AXI_BURST_MASTER_4K_CHECK_EN
    resp_4k = 2'b10; err_4k = 1'b1;
`else
    resp_4k = 2'b00; err_4k = 1'b0;
`endif
    //            wr    addr      len    id     strb   dbase         gap  rlast slverr bresp exp  err
    vecs[0] = mk(1'b1, 16'h0100, 8'd3, 8'h11, 4'hF, 32'h0000_00A0, 1'b0, -1, -1, 2'b00, 2'b00, 1'b0);
    vecs[1] = mk(1'b0, 16'h0040, 8'd7, 8'h22, 4'hF, 32'h0,         1'b0, -1, -1, 2'b00, 2'b00, 1'b0);
    vecs[2] = mk(1'b0, 16'h0200, 8'd15, 8'h33, 4'hF, 32'h0,        1'b1, -1, -1, 2'b00, 2'b00, 1'b0);
    vecs[3] = mk(1'b0, 16'h0300, 8'd3, 8'h44, 4'hF, 32'h0,         1'b0,  1, -1, 2'b00, 2'b00, 1'b1);
    vecs[4] = mk(1'b1, 16'h0403, 8'd1, 8'h55, 4'h3, 32'h1234_5678, 1'b0, -1, -1, 2'b01, 2'b01, 1'b0);
    vecs[5] = mk(1'b0, 16'h0500, 8'd2, 8'h66, 4'hF, 32'h0,         1'b0, -1,  1, 2'b00, 2'b10, 1'b0);
    vecs[6] = mk(1'b1, 16'h0600, 8'd2, 8'h77, 4'hF, 32'hDEAD_BEE0, 1'b1, -1, -1, 2'b00, 2'b00, 1'b0);
    vecs[7] = mk(1'b1, 16'h0FF8, 8'd3, 8'h88, 4'hF, 32'h0000_00C0, 1'b0, -1, -1, 2'b00, resp_4k, err_4k);
    vecs[8] = mk(1'b0, 16'h2000, 8'd255, 8'h99, 4'hF, 32'h0,       1'b0, -1, -1, 2'b00, 2'b00, 1'b0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          64'({cmd_ready, m_axi.awvalid, m_axi.arvalid, m_axi.wvalid, m_axi.bready,
               m_axi.rready, s_wready, m_rvalid, done_valid, done_resp, done_err}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", 64'(cmd_ready), 64'd1);

    for (int i = 0; i < 9; i++) run_cmd(vecs[i]);

    // Reset in the middle of beat 2 of a len=7 write
    cfg_bresp = 2'b00; cfg_rlast_beat = -1; cfg_slverr_beat = -1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0800; cmd_len = 8'd7; cmd_id = 8'hAA;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    sent = 0;
    for (int c = 0; c < 30 && sent < 1; c++) begin
      s_wvalid = 1'b1; s_wstrb = 4'hF; s_wdata = 32'h1000 + 32'(sent);
      @(negedge clk);
      if (s_wvalid && s_wready) sent++;
      @(posedge clk);
      #1;
    end
    check("midreset_first_beat", 64'(sent), 64'd1);
    s_wdata = 32'h1001;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_quiet",
          64'({m_axi.awvalid, m_axi.arvalid, m_axi.wvalid, m_axi.bready, m_axi.rready,
               s_wready, m_rvalid, done_valid}), 64'd0);
    s_wvalid = 1'b0;
    rst_n = 1'b1;
    spur = 0;
    repeat (4) begin
      @(negedge clk);
      if (done_valid) spur++;
    end
    check("midreset_no_done", 64'(spur), 64'd0);
    check("midreset_idle", 64'(cmd_ready), 64'd1);
    run_cmd(mk(1'b0, 16'h0900, 8'd0, 8'hBB, 4'hF, 32'h0, 1'b0, -1, -1, 2'b00, 2'b00, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi_burst_master.md
# axi_burst_master

Single-outstanding AXI4 master that turns a simple command (direction, address, length, ID) into one INCR burst, sourcing write beats from a valid/ready stream and delivering read beats to a valid/ready stream. It is the initiator counterpart to the testbench AXI4 RAM slave. It drives RAM traffic in DMA benches and serves as the memory-side engine for future DMA datapath blocks.

## Interface
- DATA_WIDTH, 32, AXI data width; power of two, at least 8.
- ADDR_WIDTH, 16, AXI address width.
- STRB_WIDTH, DATA_WIDTH/8, byte strobes per beat.
- ID_WIDTH, 8, AXI ID width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_WIDTH  start byte address.
- cmd_len  in  8  beats minus 1 (0..255).
- cmd_id  in  ID_WIDTH  AXI ID for the burst.
- s_wdata / s_wstrb / s_wvalid / s_wready  in/in/in/out  DATA_WIDTH/STRB_WIDTH/1/1  write beat stream.
- m_rdata / m_rlast / m_rvalid / m_rready  out/out/out/in  DATA_WIDTH/1/1/1  read beat stream.
- done_valid  out  1  one-cycle completion pulse.
- done_resp  out  2  burst response: BRESP for writes; worst RRESP for reads.
- done_err  out  1  rlast/beat-count mismatch, or a rejected command.
- m_axi_aw*, m_axi_w*, m_axi_b*, m_axi_ar*, m_axi_r*  full AXI4 master port. Widths match the slave side: len 8, size 3, burst 2, lock 1, cache 4, prot 3, resp 2.

## Operation
- FSM states: IDLE, AW, W, B, AR, R, DONE.
- IDLE
  - cmd_ready = 1.
  - On cmd_valid, latch the command and go to AW (write) or AR (read).
- Address latching: cmd_addr low $clog2(STRB_WIDTH) bits are forced to 0 when latched.
- Fixed AXI attributes:
  - awsize/arsize = $clog2(STRB_WIDTH).
  - burst = INCR (2'b01), lock = 0, cache = 4'b0011, prot = 3'b000.
- AW: hold awvalid with stable fields until awready, then go to W.
- W: combinational pass-through.
  - m_axi_wvalid = s_wvalid.
  - s_wready = m_axi_wready.
  - wdata/wstrb pass from the stream.
  - wlast = (beat_cnt == len).
  - beat_cnt increments per accepted beat.
  - After the last beat, go to B.
- B: bready = 1. On bvalid, capture bresp and go to DONE. bid is not checked.
- AR: hold arvalid until arready, then go to R.
- R: combinational pass-through.
  - m_rvalid = m_axi_rvalid.
  - m_axi_rready = m_rready.
  - m_rdata/m_rlast pass from the slave.
  - On each beat, resp_acc = max(resp_acc, rresp).
  - Set err if rlast != (beat_cnt == len).
  - The beat with beat_cnt == len ends the burst and moves to DONE, whether or not rlast is set.
- DONE: done_valid = 1 for exactly one cycle with done_resp/done_err, then IDLE.
- Stream ready and valid are 0 in every state other than W (write stream) and R (read stream).

## Timing
- Reset values:
  - All valid and ready outputs = 0, including cmd_ready, awvalid, wvalid, bready, arvalid, rready, s_wready, m_rvalid and done_valid.
  - done_resp = 0, done_err = 0, FSM = IDLE.
  - cmd_ready rises the first cycle after rst_n deasserts.
- Command accepted at edge N: awvalid or arvalid is 1 from cycle N+1.
- AW/AR handshake at edge M: first wvalid/rready is possible in cycle M+1.
- Beat throughput: one beat per cycle when both sides are ready.
- Response to done:
  - B handshake at edge K: done_valid in cycle K+1.
  - Last R beat at edge K: done_valid in cycle K+1.
- Back-to-back: cmd_ready = 1 again the cycle after done_valid. Minimum command period = len + 5 cycles.
- rst_n low mid-burst:
  - Returns to IDLE at the next edge; all valids drop.
  - The burst is abandoned with no done pulse.

## Configuration
- AXI_BURST_MASTER_4K_CHECK_EN
  - Defined: a command whose burst crosses a 4 KB boundary, i.e. (addr[11:0] + (len+1)*STRB_WIDTH) > 4096, is accepted but not issued. The FSM goes IDLE -> DONE with done_resp = 2'b10 and done_err = 1.
  - Undefined: no check; every command is issued as given.

## Test plan
- Write len=3 at 0x0100, stream data 0xA0..0xA3 with full strobes -> four W beats, wlast on the 4th; slave memory holds 0xA0..0xA3 at 0x100..0x10C; done_resp = 0, done_err = 0.
- Read len=7 at 0x0040 from RAM preloaded with mem[i] = i*8 -> m_rdata = 0x80, 0x88 … 0xB8, m_rlast on beat 8, done_err = 0.
- Read len=15 with m_rready toggling 1/0 each cycle -> all 16 beats delivered in order, none duplicated or dropped; done_valid exactly once.
- rst_n asserted for 1 cycle during beat 2 of a len=7 write -> all valids 0 the next cycle, no done pulse; a following len=0 read completes normally.
- Slave returns rlast on beat 2 of a len=3 read -> done_err = 1 after beat 4.
- With AXI_BURST_MASTER_4K_CHECK_EN defined: write len=3 at 0x0FF8, DATA_WIDTH=32 -> no awvalid; done_resp = 2'b10, done_err = 1. Without the macro: the burst is issued.
